psr_bank: RTL and testbench

- Parametrised successor of the single CPSR flag register.
- Holds the CPSR plus NBANK-1 banked SPSRs (bank 0 = user, no SPSR).
- Adds per-flag conditional update, byte-lane MSR writes, exception entry/return with nested bank tracking, pipeline stall, and an error pulse.
- Sits in the execute/writeback stage: the ALU drives the flags, the exception unit drives entry/return, and the MSR path drives writes.

---
 rtl/psr_bank.sv | 119 +++++++++++
 tb/tb_psr_bank.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/psr_bank.sv
// Banked program status register: the CPSR plus one SPSR and one return-bank link
// per exception bank. The bank is entered on exception entry and left on return.
module psr_bank #(
  parameter int          FULLW       = 32,
  parameter int          FLAGSW      = 4,
  parameter int          FLAGS_START = 28,
  parameter int          MODEW       = 5,
  parameter int          IBIT        = 7,
  parameter int          NBANK       = 4,
  parameter logic [31:0] RESET_VAL   = 32'h0000_00D3,
  localparam int         BW          = (NBANK > 1) ? $clog2(NBANK) : 1,
  localparam int         NLANE       = FULLW / 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic [FLAGSW-1:0] setflags_i,
  input  logic [FLAGSW-1:0] flagswd_i,
  input  logic              exc_req_i,
  input  logic [BW-1:0]     exc_bank_i,
  input  logic [MODEW-1:0]  exc_mode_i,
  input  logic              exc_ret_i,
  input  logic              msr_we_i,
  input  logic              msr_spsr_i,
  input  logic [NLANE-1:0]  msr_be_i,
  input  logic [FULLW-1:0]  msr_wd_i,
  output logic [FULLW-1:0]  cpsr_o,
  output logic [FULLW-1:0]  spsr_o,
  output logic [BW-1:0]     cur_bank_o,
  output logic              irq_masked_o,
  output logic              err_o
);

  logic [FULLW-1:0] cpsr_q, cpsr_d;
  logic [BW-1:0]    cur_bank_q, cur_bank_d;
  logic             err_q, err_d;
  // Entry 0 of each array belongs to the user bank and is never written.
  logic [FULLW-1:0] spsr_q [NBANK];
  logic [FULLW-1:0] spsr_d [NBANK];
  logic [BW-1:0]    prev_q [NBANK];
  logic [BW-1:0]    prev_d [NBANK];

  always_comb begin
    cpsr_d     = cpsr_q;
    cur_bank_d = cur_bank_q;
    err_d      = 1'b0;
    spsr_d     = spsr_q;
    prev_d     = prev_q;

    if (stall_i) begin
      err_d = 1'b0;
    end else if (exc_req_i) begin
      if (exc_bank_i == '0 || int'(exc_bank_i) >= NBANK) begin
        err_d = 1'b1;
      end else begin
        spsr_d[exc_bank_i]     = cpsr_q;
        prev_d[exc_bank_i]     = cur_bank_q;
        cur_bank_d             = exc_bank_i;
        cpsr_d[MODEW-1:0]      = exc_mode_i;
        cpsr_d[IBIT]           = 1'b1;
      end
    end else if (exc_ret_i) begin
      if (cur_bank_q == '0) begin
        err_d = 1'b1;
      end else begin
        cpsr_d     = spsr_q[cur_bank_q];
        cur_bank_d = prev_q[cur_bank_q];
      end
    end else if (msr_we_i) begin
      if (!msr_spsr_i) begin
        // User mode may only touch the flag byte; other lanes drop silently.
        for (int k = 0; k < NLANE; k++) begin
          if (msr_be_i[k] && (cur_bank_q != '0 || k == NLANE - 1)) begin
            cpsr_d[8*k +: 8] = msr_wd_i[8*k +: 8];
          end
        end
      end else if (cur_bank_q == '0) begin
        err_d = 1'b1;
      end else begin
        for (int k = 0; k < NLANE; k++) begin
          if (msr_be_i[k]) begin
            spsr_d[cur_bank_q][8*k +: 8] = msr_wd_i[8*k +: 8];
          end
        end
      end
    end else begin
      for (int i = 0; i < FLAGSW; i++) begin
        if (setflags_i[i]) begin
          cpsr_d[FLAGS_START+i] = flagswd_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cpsr_q     <= RESET_VAL[FULLW-1:0];
      cur_bank_q <= '0;
      err_q      <= 1'b0;
      for (int b = 0; b < NBANK; b++) begin
        spsr_q[b] <= '0;
        prev_q[b] <= '0;
      end
    end else begin
      cpsr_q     <= cpsr_d;
      cur_bank_q <= cur_bank_d;
      err_q      <= err_d;
      spsr_q     <= spsr_d;
      prev_q     <= prev_d;
    end
  end

  assign cpsr_o       = cpsr_q;
  assign spsr_o       = (cur_bank_q == '0) ? '0 : spsr_q[cur_bank_q];
  assign cur_bank_o   = cur_bank_q;
  assign irq_masked_o = cpsr_q[IBIT];
  assign err_o        = err_q;

endmodule

// File: tb/tb_psr_bank.sv
// Directed bench for psr_bank: reset, flags, entry/return, nesting, errors,
// MSR lanes, stall/priority and asynchronous reset mid-nest.
module tb_psr_bank;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        stall_i;
  logic [3:0]  setflags_i, flagswd_i;
  logic        exc_req_i;
  logic [1:0]  exc_bank_i;
  logic [4:0]  exc_mode_i;
  logic        exc_ret_i;
  logic        msr_we_i, msr_spsr_i;
  logic [3:0]  msr_be_i;
  logic [31:0] msr_wd_i;
  logic [31:0] cpsr_o, spsr_o;
  logic [1:0]  cur_bank_o;
  logic        irq_masked_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;

  psr_bank dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i),
    .setflags_i(setflags_i), .flagswd_i(flagswd_i),
    .exc_req_i(exc_req_i), .exc_bank_i(exc_bank_i), .exc_mode_i(exc_mode_i),
    .exc_ret_i(exc_ret_i), .msr_we_i(msr_we_i), .msr_spsr_i(msr_spsr_i),
    .msr_be_i(msr_be_i), .msr_wd_i(msr_wd_i),
    .cpsr_o(cpsr_o), .spsr_o(spsr_o), .cur_bank_o(cur_bank_o),
    .irq_masked_o(irq_masked_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall_i    = 1'b0;
    setflags_i = '0;
    flagswd_i  = '0;
    exc_req_i  = 1'b0;
    exc_bank_i = '0;
    exc_mode_i = '0;
    exc_ret_i  = 1'b0;
    msr_we_i   = 1'b0;
    msr_spsr_i = 1'b0;
    msr_be_i   = '0;
    msr_wd_i   = '0;
  endtask

  // Apply the currently driven inputs for one edge, then sample and go idle.
  task automatic tick();
    @(posedge clk_i);
    #1;
    idle();
  endtask

  task automatic state(input string tag, input logic [31:0] c, input logic [1:0] b,
                       input logic [31:0] s);
    chk({tag, ".cpsr"}, cpsr_o, c);
    chk({tag, ".bank"}, {30'd0, cur_bank_o}, {30'd0, b});
    chk({tag, ".spsr"}, spsr_o, s);
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    idle();
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  task automatic enter(input logic [1:0] b, input logic [4:0] m);
    exc_req_i = 1'b1; exc_bank_i = b; exc_mode_i = m;
    tick();
  endtask

  task automatic ret();
    exc_ret_i = 1'b1;
    tick();
  endtask

  task automatic msr(input logic sp, input logic [3:0] be, input logic [31:0] wd);
    msr_we_i = 1'b1; msr_spsr_i = sp; msr_be_i = be; msr_wd_i = wd;
    tick();
  endtask

  initial begin
    do_reset();
    state("reset", 32'h0000_00D3, 2'd0, 32'h0);
    chk("reset.err", {31'd0, err_o}, 32'd0);
    chk("reset.irq", {31'd0, irq_masked_o}, 32'd1);

    setflags_i = 4'b1010; flagswd_i = 4'b1111; tick();
    chk("flags1", cpsr_o, 32'hA000_00D3);
    setflags_i = 4'b1111; flagswd_i = 4'b0110; tick();
    chk("flags2", cpsr_o, 32'h6000_00D3);

    // Entry squashes same-cycle flag update.
    setflags_i = 4'hF; flagswd_i = 4'h0;
    enter(2'd2, 5'h12);
    state("entry", 32'h6000_00D2, 2'd2, 32'h6000_00D3);
    chk("entry.err", {31'd0, err_o}, 32'd0);
    ret();
    state("return", 32'h6000_00D3, 2'd0, 32'h0);

    // Build user CPSR 0x10 via bank 1's SPSR, then nest 1 -> 3.
    enter(2'd1, 5'h11);
    msr(1'b1, 4'b1111, 32'h0000_0010);
    chk("spsr_wr", spsr_o, 32'h0000_0010);
    ret();
    state("user10", 32'h0000_0010, 2'd0, 32'h0);
    chk("user10.irq", {31'd0, irq_masked_o}, 32'd0);
    enter(2'd1, 5'h11);
    state("nest1", 32'h0000_0091, 2'd1, 32'h0000_0010);
    enter(2'd3, 5'h1B);
    state("nest3", 32'h0000_009B, 2'd3, 32'h0000_0091);
    ret();
    state("unwind1", 32'h0000_0091, 2'd1, 32'h0000_0010);
    ret();
    state("unwind0", 32'h0000_0010, 2'd0, 32'h0);

    // Illegal requests at bank 0: one-cycle err, no state change.
    ret();
    chk("err_ret", {31'd0, err_o}, 32'd1);
    state("err_ret", 32'h0000_0010, 2'd0, 32'h0);
    tick();
    chk("err_ret.clr", {31'd0, err_o}, 32'd0);
    enter(2'd0, 5'h1F);
    chk("err_bank0", {31'd0, err_o}, 32'd1);
    state("err_bank0", 32'h0000_0010, 2'd0, 32'h0);
    tick();
    chk("err_bank0.clr", {31'd0, err_o}, 32'd0);
    msr(1'b1, 4'b1111, 32'hFFFF_FFFF);
    chk("err_msr", {31'd0, err_o}, 32'd1);
    state("err_msr", 32'h0000_0010, 2'd0, 32'h0);
    tick();
    chk("err_msr.clr", {31'd0, err_o}, 32'd0);

    // MSR lanes: user mode only reaches the top byte.
    do_reset();
    msr(1'b0, 4'b1111, 32'hF000_00FF);
    chk("msr_user", cpsr_o, 32'hF000_00D3);
    chk("msr_user.err", {31'd0, err_o}, 32'd0);
    enter(2'd1, 5'h11);
    state("msr_enter", 32'hF000_00D1, 2'd1, 32'hF000_00D3);
    msr(1'b0, 4'b1111, 32'hF000_00FF);
    chk("msr_priv", cpsr_o, 32'hF000_00FF);
    chk("msr_priv.irq", {31'd0, irq_masked_o}, 32'd1);
    msr(1'b0, 4'b0010, 32'h1234_AB56);
    chk("msr_lane1", cpsr_o, 32'hF000_ABFF);
    msr(1'b1, 4'b0001, 32'hFFFF_FF12);
    chk("msr_spsr_lane0", spsr_o, 32'hF000_0012);
    // MSR beats setflags.
    msr_we_i = 1'b1; msr_be_i = 4'b0100; msr_wd_i = 32'h0055_0000;
    setflags_i = 4'hF; flagswd_i = 4'h0;
    tick();
    chk("msr_over_flags", cpsr_o, 32'hF055_ABFF);

    // Stall holds everything.
    stall_i = 1'b1; exc_req_i = 1'b1; exc_bank_i = 2'd2; exc_mode_i = 5'h13;
    setflags_i = 4'hF; flagswd_i = 4'h0;
    tick();
    state("stall", 32'hF055_ABFF, 2'd1, 32'hF000_0012);
    chk("stall.err", {31'd0, err_o}, 32'd0);
    // Stall also suppresses an otherwise-illegal request's err.
    stall_i = 1'b1; exc_ret_i = 1'b1; exc_req_i = 1'b1; exc_bank_i = 2'd0;
    tick();
    chk("stall_err", {31'd0, err_o}, 32'd0);

    // Entry beats return.
    exc_req_i = 1'b1; exc_bank_i = 2'd2; exc_mode_i = 5'h13; exc_ret_i = 1'b1;
    tick();
    state("req_over_ret", 32'hF055_ABF3, 2'd2, 32'hF055_ABFF);
    // Re-entry into the current bank links back to itself.
    enter(2'd2, 5'h17);
    state("reenter", 32'hF055_ABF7, 2'd2, 32'hF055_ABF3);
    ret();
    state("reenter_ret", 32'hF055_ABF3, 2'd2, 32'hF055_ABF3);

    // Asynchronous reset mid-nest.
    @(posedge clk_i);
    #3 rst_n_i = 1'b0;
    #1;
    state("async_rst", 32'h0000_00D3, 2'd0, 32'h0);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    tick();
    state("post_rst", 32'h0000_00D3, 2'd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
